// File: rtl/uart_port_ctrl_pkg.sv
// uart_port_ctrl_pkg: shared UART address map, bus op codes and FSM state encodings.
package uart_port_ctrl_pkg;

    localparam logic [17:0] UART_ADDR_DATA = 18'h0BF00;
    localparam logic [17:0] UART_ADDR_STAT = 18'h0BF01;

    localparam logic RAM_OP_RD = 1'b0;
    localparam logic RAM_OP_WR = 1'b1;

    typedef logic [3:0] uart_state_t;

    localparam uart_state_t ST_IDLE     = 4'd0;
    localparam uart_state_t ST_RD_WAIT  = 4'd1;
    localparam uart_state_t ST_RD_STB   = 4'd2;
    localparam uart_state_t ST_WR_SETUP = 4'd3;
    localparam uart_state_t ST_WR_STB   = 4'd4;
    localparam uart_state_t ST_WR_HOLD  = 4'd5;
    localparam uart_state_t ST_WR_TBRE  = 4'd6;
    localparam uart_state_t ST_WR_TSRE  = 4'd7;
    localparam uart_state_t ST_DONE     = 4'd8;

    function automatic logic [15:0] status_word(input logic data_ready, input logic tbre, input logic tsre);
        return {14'b0, data_ready, tbre & tsre};
    endfunction

endpackage

// File: rtl/uart_port_ctrl.sv
// uart_port_ctrl: multi-cycle UART access engine on the shared RAM1 bus.
// Generates rdn/wrn strobes, stalls the pipeline and keeps SRAM1 off until the handshake finishes.
module uart_port_ctrl
    import uart_port_ctrl_pkg::*;
#(
    parameter logic [17:0] ADDR_DATA  = UART_ADDR_DATA,
    parameter logic [17:0] ADDR_STAT  = UART_ADDR_STAT,
    parameter int          SETUP_CYC  = 1,
    parameter int          STROBE_CYC = 2,
    parameter int          TX_TIMEOUT = 1023
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        req,
    input  logic        op,
    input  logic [17:0] addr,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        ack,
    output logic        err,
    output logic        pause,
    output logic        ram1_off,
    input  logic [15:0] bus_data_i,
    output logic [15:0] bus_data_o,
    output logic        bus_data_oe,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn
);

    localparam logic [9:0] SETUP_LAST = 10'(SETUP_CYC - 1);
    localparam logic [9:0] STB_LAST   = 10'(STROBE_CYC - 1);
    localparam logic [9:0] TMO        = 10'(TX_TIMEOUT);

    uart_state_t state;
    logic [9:0]  cnt;
    logic [15:0] rd_q;
    logic [15:0] wr_q;
    logic        err_q;

    logic stat_hit;
    logic data_hit;

    assign stat_hit = (state == ST_IDLE) && req && (addr == ADDR_STAT);
    assign data_hit = (state == ST_IDLE) && req && (addr == ADDR_DATA);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (data_hit) begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                    rd_q  <= '0;
                    wr_q  <= data_i;
                    state <= (op == RAM_OP_WR) ? ST_WR_SETUP : (data_ready ? ST_RD_STB : ST_RD_WAIT);
                end
                ST_RD_WAIT: if (data_ready) begin
                    cnt   <= '0;
                    state <= ST_RD_STB;
                end
                ST_RD_STB: if (cnt == STB_LAST) begin
                    rd_q  <= bus_data_i;
                    state <= ST_DONE;
                end else cnt <= cnt + 10'd1;
                ST_WR_SETUP: if (cnt == SETUP_LAST) begin
                    cnt   <= '0;
                    state <= ST_WR_STB;
                end else cnt <= cnt + 10'd1;
                ST_WR_STB: if (cnt == STB_LAST) state <= ST_WR_HOLD;
                else cnt <= cnt + 10'd1;
                ST_WR_HOLD: begin
                    cnt   <= '0;
                    state <= ST_WR_TBRE;
                end
                ST_WR_TBRE: if (tbre) begin
                    cnt   <= '0;
                    state <= ST_WR_TSRE;
                end else if (cnt == TMO) begin
                    err_q <= 1'b1;
                    state <= ST_DONE;
                end else cnt <= cnt + 10'd1;
                ST_WR_TSRE: if (tsre) state <= ST_DONE;
                else if (cnt == TMO) begin
                    err_q <= 1'b1;
                    state <= ST_DONE;
                end else cnt <= cnt + 10'd1;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the low byte ever crosses the UART; masking keeps the upper latch bits harmless.
    assign data_o      = (stat_hit && op == RAM_OP_RD) ? status_word(data_ready, tbre, tsre)
                       : (state == ST_DONE) ? (rd_q & 16'h00FF) : 16'h0000;
    assign ack         = stat_hit || (state == ST_DONE);
    assign err         = (state == ST_DONE) && err_q;
    assign pause       = data_hit || ((state != ST_IDLE) && (state != ST_DONE));
    assign ram1_off    = pause || (state == ST_DONE);
    assign rdn         = state != ST_RD_STB;
    assign wrn         = state != ST_WR_STB;
    assign bus_data_oe = (state == ST_WR_SETUP) || (state == ST_WR_STB) || (state == ST_WR_HOLD);
    assign bus_data_o  = wr_q & 16'h00FF;

endmodule

// File: tb/tb_uart_port_ctrl.sv
// tb_uart_port_ctrl: directed stimulus with a scoreboard of expected acks checked by a separate monitor.
module tb_uart_port_ctrl;

    localparam logic [17:0] A_DATA = 18'h0BF00;
    localparam logic [17:0] A_STAT = 18'h0BF01;

    logic        clk_50MHz = 1'b0;
    logic        rst, req, op, data_ready, tbre, tsre;
    logic [17:0] addr;
    logic [15:0] data_i, bus_data_i;
    logic [15:0] data_o, bus_data_o;
    logic        ack, err, pause, ram1_off, bus_data_oe, rdn, wrn;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    uart_port_ctrl dut (
        .clk_50MHz(clk_50MHz), .rst(rst), .req(req), .op(op), .addr(addr), .data_i(data_i),
        .data_o(data_o), .ack(ack), .err(err), .pause(pause), .ram1_off(ram1_off),
        .bus_data_i(bus_data_i), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    always @(negedge clk_50MHz) begin
        if (ack === 1'b1) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got ack=1 data_o=%h expected no ack", data_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_err", {31'b0, err}, {31'b0, e.err});
                if (e.rd) chk("ack_data", {16'b0, data_o}, {16'b0, e.data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req = 1'b0; op = 1'b0; addr = '0; data_i = '0; bus_data_i = '0;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        repeat (3) step();
        @(negedge clk_50MHz);
        chk("rst_rdn", {31'b0, rdn}, 1);
        chk("rst_wrn", {31'b0, wrn}, 1);
        chk("rst_oe", {31'b0, bus_data_oe}, 0);
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_data_o", {16'b0, data_o}, 0);
        chk("rst_pause", {31'b0, pause}, 0);
        step();
        rst = 1'b0;
        step();

        // status read: same-cycle answer
        req = 1'b1; op = 1'b0; addr = A_STAT; data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
        q.push_back('{1'b1, 16'h0002, 1'b0});
        @(negedge clk_50MHz);
        chk("stat_ack", {31'b0, ack}, 1);
        chk("stat_pause", {31'b0, pause}, 0);
        chk("stat_ram1_off", {31'b0, ram1_off}, 0);
        step();

        // status write: ack, no strobe
        op = 1'b1;
        q.push_back('{1'b0, 16'h0000, 1'b0});
        @(negedge clk_50MHz);
        chk("statwr_ack", {31'b0, ack}, 1);
        chk("statwr_wrn", {31'b0, wrn}, 1);
        chk("statwr_pause", {31'b0, pause}, 0);
        step();

        // non-matching address ignored
        op = 1'b0; addr = 18'h00123;
        repeat (2) begin
            @(negedge clk_50MHz);
            chk("nomatch_ack", {31'b0, ack}, 0);
            chk("nomatch_pause", {31'b0, pause}, 0);
            chk("nomatch_ram1_off", {31'b0, ram1_off}, 0);
            chk("nomatch_rdn", {31'b0, rdn}, 1);
            step();
        end

        // data read, flag already high; bus changes so only last strobe cycle latches
        req = 1'b1; op = 1'b0; addr = A_DATA; data_ready = 1'b1; bus_data_i = 16'h3C99;
        q.push_back('{1'b1, 16'h0041, 1'b0});
        @(negedge clk_50MHz);
        chk("rd_t0_pause", {31'b0, pause}, 1);
        chk("rd_t0_rdn", {31'b0, rdn}, 1);
        step();
        addr = A_STAT;
        @(negedge clk_50MHz);
        chk("rd_t1_rdn", {31'b0, rdn}, 0);
        step();
        bus_data_i = 16'h3C41;
        @(negedge clk_50MHz);
        chk("rd_t2_rdn", {31'b0, rdn}, 0);
        step();
        req = 1'b0;
        @(negedge clk_50MHz);
        chk("rd_t3_ack", {31'b0, ack}, 1);
        chk("rd_t3_rdn", {31'b0, rdn}, 1);
        chk("rd_t3_pause", {31'b0, pause}, 0);
        chk("rd_t3_ram1_off", {31'b0, ram1_off}, 1);
        step();
        @(negedge clk_50MHz);
        chk("rd_t4_ack", {31'b0, ack}, 0);
        step();

        // blocking read: data_ready low for 10 cycles
        req = 1'b1; op = 1'b0; addr = A_DATA; data_ready = 1'b0; bus_data_i = 16'hA5C3;
        q.push_back('{1'b1, 16'h00C3, 1'b0});
        @(negedge clk_50MHz);
        chk("brd_t0_pause", {31'b0, pause}, 1);
        step();
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50MHz);
            chk("brd_wait_rdn", {31'b0, rdn}, 1);
            chk("brd_wait_pause", {31'b0, pause}, 1);
            step();
        end
        data_ready = 1'b1;
        @(negedge clk_50MHz);
        chk("brd_w_rdn", {31'b0, rdn}, 1);
        step();
        data_ready = 1'b0;
        @(negedge clk_50MHz);
        chk("brd_w1_rdn", {31'b0, rdn}, 0);
        step();
        @(negedge clk_50MHz);
        chk("brd_w2_rdn", {31'b0, rdn}, 0);
        step();
        @(negedge clk_50MHz);
        chk("brd_w3_ack", {31'b0, ack}, 1);
        step();

        // write with delayed tbre/tsre
        req = 1'b1; op = 1'b1; addr = A_DATA; data_i = 16'h1255; tbre = 1'b0; tsre = 1'b0;
        q.push_back('{1'b0, 16'h0000, 1'b0});
        @(negedge clk_50MHz);
        chk("wr_t0_oe", {31'b0, bus_data_oe}, 0);
        chk("wr_t0_pause", {31'b0, pause}, 1);
        step();
        req = 1'b0; data_i = 16'hFFFF;
        for (int off = 1; off <= 13; off++) begin
            tbre = off >= 9;
            tsre = off >= 12;
            @(negedge clk_50MHz);
            chk("wr_wrn", {31'b0, wrn}, {31'b0, !(off == 2 || off == 3)});
            chk("wr_oe", {31'b0, bus_data_oe}, {31'b0, off >= 1 && off <= 4});
            chk("wr_ack", {31'b0, ack}, {31'b0, off == 13});
            chk("wr_pause", {31'b0, pause}, {31'b0, off < 13});
            if (off == 1) chk("wr_bus_data_o", {16'b0, bus_data_o}, 32'h0055);
            step();
        end

        // write with tbre stuck low times out
        req = 1'b1; op = 1'b1; addr = A_DATA; data_i = 16'h0077; tbre = 1'b0; tsre = 1'b0;
        q.push_back('{1'b0, 16'h0000, 1'b1});
        step();
        req = 1'b0;
        n = 1;
        @(negedge clk_50MHz);
        while (ack !== 1'b1 && n < 1100) begin
            step();
            n++;
            @(negedge clk_50MHz);
        end
        chk("tmo_ack_cycle", n, 1029);
        step();

        // next write with flags high completes normally at T+7
        req = 1'b1; op = 1'b1; addr = A_DATA; data_i = 16'h00AA; tbre = 1'b1; tsre = 1'b1;
        q.push_back('{1'b0, 16'h0000, 1'b0});
        step();
        req = 1'b0;
        n = 1;
        @(negedge clk_50MHz);
        while (ack !== 1'b1 && n < 50) begin
            step();
            n++;
            @(negedge clk_50MHz);
        end
        chk("wr2_ack_cycle", n, 7);
        step();

        // reset during RD_STB
        req = 1'b1; op = 1'b0; addr = A_DATA; data_ready = 1'b1;
        step();
        req = 1'b0;
        @(negedge clk_50MHz);
        chk("rstrd_rdn_low", {31'b0, rdn}, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk_50MHz);
        chk("rstrd_rdn", {31'b0, rdn}, 1);
        chk("rstrd_oe", {31'b0, bus_data_oe}, 0);
        chk("rstrd_pause", {31'b0, pause}, 0);
        step();

        // reset during WR_STB
        req = 1'b1; op = 1'b1; addr = A_DATA; data_i = 16'h0033;
        step();
        req = 1'b0;
        step();
        @(negedge clk_50MHz);
        chk("rstwr_wrn_low", {31'b0, wrn}, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk_50MHz);
        chk("rstwr_wrn", {31'b0, wrn}, 1);
        chk("rstwr_rdn", {31'b0, rdn}, 1);
        chk("rstwr_oe", {31'b0, bus_data_oe}, 0);
        chk("rstwr_pause", {31'b0, pause}, 0);
        chk("rstwr_ack", {31'b0, ack}, 0);
        step();
        step();

        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
